// File: rtl/updown_mod_counter.sv
// Synchronous loadable up/down modulo-MODULUS counter with IDLE/RUN/DONE control and a registered terminal-count pulse.
// Define UPDOWN_GRAY_OUT_EN to add a registered Gray-coded copy of the count on port q_gray.
module updown_mod_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             oneshot,
  input  logic             start,
  output logic [WIDTH-1:0] q,
`ifdef UPDOWN_GRAY_OUT_EN
  output logic [WIDTH-1:0] q_gray,
`endif
  output logic             tc,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // MODULUS may equal 2**WIDTH, so the saturation compare needs one extra bit.
  localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             tc_q, tc_d;
  logic [WIDTH-1:0] term_val;
  logic [WIDTH-1:0] din_sat;

  assign term_val = up ? MAX_Q : '0;
  assign din_sat  = ({1'b0, din} >= MOD_EXT) ? MAX_Q : din;

  // NOTE: every signal gets a default before the branches so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    tc_d    = 1'b0;
    if (load) begin
      q_d     = din_sat;
      state_d = IDLE;
    end else if (start && state_q != RUN) begin
      state_d = RUN;
      if (state_q == DONE) q_d = up ? '0 : MAX_Q;
    end else if (state_q == RUN && en) begin
      if (q_q == term_val) begin
        tc_d = 1'b1;
        if (oneshot) state_d = DONE;
        else         q_d     = up ? '0 : MAX_Q;
      end else begin
        q_d = up ? q_q + WIDTH'(1) : q_q - WIDTH'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      tc_q    <= tc_d;
    end
  end

`ifdef UPDOWN_GRAY_OUT_EN
  // Encoded from the next count so q and q_gray always describe the same value.
  logic [WIDTH-1:0] gray_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) gray_q <= '0;
    else      gray_q <= (q_d >> 1) ^ q_d;
  end
  assign q_gray = gray_q;
`endif

  assign q    = q_q;
  assign tc   = tc_q;
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_updown_mod_counter.sv
// Self-checking bench for updown_mod_counter (WIDTH=4, MODULUS=10): vector table, reset corner case, random run vs model.
module tb_updown_mod_counter;

  localparam int W = 4;
  localparam int M = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0, up = 1'b1, load = 1'b0, oneshot = 1'b0, start = 1'b0;
  logic [W-1:0] din = '0;
  logic [W-1:0] q;
  logic         tc, busy, done;
`ifdef UPDOWN_GRAY_OUT_EN
  logic [W-1:0] q_gray;
`endif

  int checks = 0;
  int failures = 0;

  updown_mod_counter #(.WIDTH(W), .MODULUS(M)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .din(din),
    .oneshot(oneshot), .start(start), .q(q),
`ifdef UPDOWN_GRAY_OUT_EN
    .q_gray(q_gray),
`endif
    .tc(tc), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         ld;
    logic [W-1:0] d;
    logic         st, e, u, os;
    logic [W-1:0] eq;
    logic         etc, ebusy, edone;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int eq, input int etc, input int eb, input int ed);
    logic [W-1:0] gq;
    gq = W'(eq);
    check({tag, "_q"}, 32'(q), 32'(eq));
    check({tag, "_tc"}, 32'(tc), 32'(etc));
    check({tag, "_busy"}, 32'(busy), 32'(eb));
    check({tag, "_done"}, 32'(done), 32'(ed));
`ifdef UPDOWN_GRAY_OUT_EN
    check({tag, "_gray"}, 32'(q_gray), 32'((gq >> 1) ^ gq));
`else
    gq = '0;
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic ld, input int d, input logic st, input logic e, input logic u,
                     input logic os, input int eq, input logic etc, input logic eb, input logic ed);
    vec_t v;
    v.ld = ld; v.d = W'(d); v.st = st; v.e = e; v.u = u; v.os = os;
    v.eq = W'(eq); v.etc = etc; v.ebusy = eb; v.edone = ed;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic ld, input int d, input logic st, input logic e, input logic u, input logic os);
    load = ld; din = W'(d); start = st; en = e; up = u; oneshot = os;
  endtask

  // Reference model state: count, running/finished flags, pulse.
  int mq, mtc;
  bit mrun, mfin;

  initial begin
    // Free-running up count through the wrap.
    add(1, 0, 0, 0, 1, 0,  0, 0, 0, 0);
    add(0, 0, 1, 1, 1, 0,  0, 0, 1, 0);
    for (int i = 1; i <= 11; i++) add(0, 0, 0, 1, 1, 0, i % M, (i == 10), 1, 0);
    // One-shot down count, hold at 0, restart from DONE reloads MODULUS-1.
    add(1, 3, 0, 0, 0, 1,  3, 0, 0, 0);
    add(0, 0, 1, 1, 0, 1,  3, 0, 1, 0);
    add(0, 0, 0, 1, 0, 1,  2, 0, 1, 0);
    add(0, 0, 0, 1, 0, 1,  1, 0, 1, 0);
    add(0, 0, 0, 1, 0, 1,  0, 0, 1, 0);
    add(0, 0, 0, 1, 0, 1,  0, 1, 0, 1);
    add(0, 0, 0, 1, 0, 1,  0, 0, 0, 1);
    add(0, 0, 1, 1, 0, 1,  9, 0, 1, 0);
    // Saturating load; en without start does nothing in IDLE.
    add(1, 15, 0, 1, 1, 0, 9, 0, 0, 0);
    add(0, 0, 0, 1, 1, 0,  9, 0, 0, 0);
    add(0, 0, 0, 1, 1, 0,  9, 0, 0, 0);
    // Load beats start and count on the same edge.
    add(1, 5, 0, 0, 1, 0,  5, 0, 0, 0);
    add(0, 0, 1, 0, 1, 0,  5, 0, 1, 0);
    add(1, 2, 1, 1, 1, 0,  2, 0, 0, 0);
    // Direction change mid-run.
    add(1, 4, 0, 0, 1, 0,  4, 0, 0, 0);
    add(0, 0, 1, 0, 1, 0,  4, 0, 1, 0);
    add(0, 0, 0, 1, 1, 0,  5, 0, 1, 0);
    add(0, 0, 0, 1, 0, 0,  4, 0, 1, 0);
    add(0, 0, 0, 1, 0, 0,  3, 0, 1, 0);
    add(0, 0, 0, 1, 0, 0,  2, 0, 1, 0);
    add(0, 0, 0, 1, 1, 0,  3, 0, 1, 0);
    add(0, 0, 0, 1, 1, 0,  4, 0, 1, 0);

    rst = 1'b0;
    #12;
    check_all("reset", 0, 0, 0, 0);
    tick();
    rst = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].ld, int'(vecs[i].d), vecs[i].st, vecs[i].e, vecs[i].u, vecs[i].os);
      tick();
      check_all($sformatf("vec%0d", i), int'(vecs[i].eq), int'(vecs[i].etc),
                int'(vecs[i].ebusy), int'(vecs[i].edone));
    end

    // Asynchronous reset in the middle of a tc pulse, then start required to resume.
    drive(1, 8, 0, 0, 1, 0); tick();
    drive(0, 0, 1, 1, 1, 0); tick(); check_all("ar_start", 8, 0, 1, 0);
    drive(0, 0, 0, 1, 1, 0); tick(); check_all("ar_q9", 9, 0, 1, 0);
    tick();                          check_all("ar_wrap", 0, 1, 1, 0);
    #2 rst = 1'b0;
    #1 check_all("ar_async", 0, 0, 0, 0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all($sformatf("ar_nostart%0d", i), 0, 0, 0, 0);
    end
    drive(0, 0, 1, 1, 1, 0); tick(); check_all("ar_restart", 0, 0, 1, 0);
    drive(0, 0, 0, 1, 1, 0); tick(); check_all("ar_count", 1, 0, 1, 0);

    // Random run against the behavioural model.
    rst = 1'b0;
    #2;
    tick();
    rst = 1'b1;
    mq = 0; mtc = 0; mrun = 0; mfin = 0;
    for (int i = 0; i < 400; i++) begin
      logic rl, rs, re, ru, ro;
      int   rd, step;
      rl = ($urandom_range(0, 15) == 0);
      rs = ($urandom_range(0, 7) == 0);
      re = ($urandom_range(0, 3) != 0);
      ru = ($urandom_range(0, 5) != 0) ? up : ~up;
      ro = ($urandom_range(0, 3) == 0);
      rd = $urandom_range(0, 15);
      drive(rl, rd, rs, re, ru, ro);
      step = ru ? 1 : M - 1;
      mtc = 0;
      if (rl) begin
        mq = (rd >= M) ? M - 1 : rd;
        mrun = 0; mfin = 0;
      end else if (rs && !mrun) begin
        if (mfin) mq = ru ? 0 : M - 1;
        mrun = 1; mfin = 0;
      end else if (mrun && re) begin
        if (mq == (ru ? M - 1 : 0)) begin
          mtc = 1;
          if (ro) begin mrun = 0; mfin = 1; end
          else mq = (mq + step) % M;
        end else begin
          mq = (mq + step) % M;
        end
      end
      tick();
      check_all($sformatf("rnd%0d", i), mq, mtc, int'(mrun), int'(mfin));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
